vga_pixel_fetch: RTL

Downstream of the VGA sync generator, on the 25 MHz `vga_clk` domain. Consumes the generator's registered `HS`, `VS` and `blank_n`, tracks the visible raster position, and reads the 160x120 Gigatron framebuffer through a synchronous-read RAM port. Each framebuffer pixel is replicated 4x4 to fill 640x480. It expands the 6-bit Gigatron colour to 24-bit RGB and delays the sync signals so they stay aligned with pixel data at the DAC/HDMI output.

---
 rtl/vga_pixel_fetch.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: tracks the visible raster position behind the sync generator,
// fetches the 160x120 framebuffer (4x4 replicated) and expands colour to 24-bit RGB.
//
// Ports:
//   vga_clk, reset       : pixel clock, synchronous active-high reset
//   hs_in, vs_in         : active-low syncs from the generator
//   blank_n_in           : 1 in the visible region
//   fb_addr, fb_rd       : synchronous-read RAM port (row*160 + col)
//   fb_data              : RAM data one clock after fb_addr/fb_rd ([1:0]=R [3:2]=G [5:4]=B)
//   vga_r/g/b            : pixel colour, 2 cycles after the inputs are sampled
//   vga_hs/vs/blank_n    : syncs delayed to stay aligned with the colour
//
// Optional build macro PIXEL_FETCH_SCANLINE_EN halves the intensity of the
// last output line of every framebuffer row (CRT scanline look).

module vga_pixel_fetch #(
  parameter int H_PIXELS   = 160,
  parameter int V_PIXELS   = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int ADDR_W     = 15
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              blank_n_in,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  input  logic [7:0]        fb_data,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n
);

  localparam logic [7:0] COL_MAX = 8'(H_PIXELS - 1);
  localparam logic [6:0] ROW_MAX = 7'(V_PIXELS - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);
  localparam logic [ADDR_W-1:0] BASE_MAX =
    ADDR_W'((V_PIXELS - 1) * H_PIXELS);
  localparam logic [SCALE_LOG2-1:0] SUB_MAX = '1;
  localparam logic [SCALE_LOG2-1:0] SUB_ONE = SCALE_LOG2'(1);

  function automatic logic [7:0] expand(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  // Position tracking
  logic                  frame_lock_q, frame_lock_d;
  logic [SCALE_LOG2-1:0] x_sub_q, x_sub_d;
  logic [7:0]            col_q, col_d;
  logic [SCALE_LOG2-1:0] y_sub_q, y_sub_d;
  logic [6:0]            row_q, row_d;
  logic [ADDR_W-1:0]     line_base_q, line_base_d;
  logic                  blank_d_q, blank_d_d;

  // Fetch stage
  logic [ADDR_W-1:0]     fb_addr_q, fb_addr_d;
  logic                  fb_rd_q, fb_rd_d;

  // Data stage: carries "this pixel was fetched" alongside the RAM latency
  logic                  rd_p_q, rd_p_d;

  // Sync delay line, two deep ahead of the output register
  logic                  hs1_q, hs1_d, hs2_q, hs2_d;
  logic                  vs1_q, vs1_d, vs2_q, vs2_d;
  logic                  bn1_q, bn1_d, bn2_q, bn2_d;

  // Output register
  logic [7:0]            vga_r_q, vga_r_d;
  logic [7:0]            vga_g_q, vga_g_d;
  logic [7:0]            vga_b_q, vga_b_d;
  logic                  vga_hs_q, vga_hs_d;
  logic                  vga_vs_q, vga_vs_d;
  logic                  vga_blank_n_q, vga_blank_n_d;

`ifdef PIXEL_FETCH_SCANLINE_EN
  logic                  dim1_q, dim1_d, dim2_q, dim2_d;
`endif

  logic                  blank_fall;
  logic                  unused_fb_bits;

  assign unused_fb_bits = ^fb_data[7:6];
  assign blank_fall     = blank_d_q & ~blank_n_in;

  always_comb begin
    frame_lock_d  = frame_lock_q;
    x_sub_d       = x_sub_q;
    col_d         = col_q;
    y_sub_d       = y_sub_q;
    row_d         = row_q;
    line_base_d   = line_base_q;
    blank_d_d     = blank_n_in;

    frame_lock_d  = frame_lock_q | ~vs_in;

    // Horizontal: replicate each column over 2**SCALE_LOG2 pixels
    if (!blank_n_in) begin
      x_sub_d = '0;
      col_d   = '0;
    end else begin
      x_sub_d = x_sub_q + SUB_ONE;
      if (x_sub_q == SUB_MAX && col_q != COL_MAX) begin
        col_d = col_q + 8'd1;
      end
    end

    // Vertical: vsync clear wins over an end-of-line on the same cycle
    unique case (1'b1)
      !vs_in: begin
        y_sub_d     = '0;
        row_d       = '0;
        line_base_d = '0;
      end
      vs_in && blank_fall: begin
        y_sub_d = y_sub_q + SUB_ONE;
        if (y_sub_q == SUB_MAX && row_q != ROW_MAX) begin
          row_d = row_q + 7'd1;
        end
        if (y_sub_q == SUB_MAX && line_base_q != BASE_MAX) begin
          line_base_d = line_base_q + LINE_STEP;
        end
      end
      default: ;
    endcase

    fb_addr_d = line_base_q + ADDR_W'(col_q);
    fb_rd_d   = frame_lock_d & blank_n_in;

    rd_p_d = fb_rd_q;

    hs1_d = hs_in;
    vs1_d = vs_in;
    bn1_d = blank_n_in;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    bn2_d = bn1_q;

    vga_hs_d      = hs2_q;
    vga_vs_d      = vs2_q;
    vga_blank_n_d = bn2_q;

    // rd_p_q is only set for locked, visible pixels, so it also blacks
    // out blanking and unlocked frames.
    vga_r_d = '0;
    vga_g_d = '0;
    vga_b_d = '0;
    if (rd_p_q) begin
      vga_r_d = expand(fb_data[1:0]);
      vga_g_d = expand(fb_data[3:2]);
      vga_b_d = expand(fb_data[5:4]);
    end

`ifdef PIXEL_FETCH_SCANLINE_EN
    dim1_d = (y_sub_q == SUB_MAX);
    dim2_d = dim1_q;
    if (dim2_q) begin
      vga_r_d = vga_r_d >> 1;
      vga_g_d = vga_g_d >> 1;
      vga_b_d = vga_b_d >> 1;
    end
`endif
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_lock_q  <= 1'b0;
      x_sub_q       <= '0;
      col_q         <= '0;
      y_sub_q       <= '0;
      row_q         <= '0;
      line_base_q   <= '0;
      blank_d_q     <= 1'b0;
      fb_addr_q     <= '0;
      fb_rd_q       <= 1'b0;
      rd_p_q        <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      bn1_q         <= 1'b0;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      bn2_q         <= 1'b0;
      vga_r_q       <= '0;
      vga_g_q       <= '0;
      vga_b_q       <= '0;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      vga_blank_n_q <= 1'b0;
`ifdef PIXEL_FETCH_SCANLINE_EN
      dim1_q        <= 1'b0;
      dim2_q        <= 1'b0;
`endif
    end else begin
      frame_lock_q  <= frame_lock_d;
      x_sub_q       <= x_sub_d;
      col_q         <= col_d;
      y_sub_q       <= y_sub_d;
      row_q         <= row_d;
      line_base_q   <= line_base_d;
      blank_d_q     <= blank_d_d;
      fb_addr_q     <= fb_addr_d;
      fb_rd_q       <= fb_rd_d;
      rd_p_q        <= rd_p_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      bn1_q         <= bn1_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
      bn2_q         <= bn2_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      vga_blank_n_q <= vga_blank_n_d;
`ifdef PIXEL_FETCH_SCANLINE_EN
      dim1_q        <= dim1_d;
      dim2_q        <= dim2_d;
`endif
    end
  end

  assign fb_addr     = fb_addr_q;
  assign fb_rd       = fb_rd_q;
  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign vga_blank_n = vga_blank_n_q;

endmodule
